// File: rtl/csr_counter_unit.sv
// Zicsr/Zicntr counter block: 64-bit mcycle/minstret with CSR read-modify-write access.
// Optional macro CSR_TIME_EN adds a prescaled 64-bit time counter behind 0xC01/0xC81.
module csr_counter_unit #(
  parameter int TIME_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icycle_inc,
  input  logic        csr_en,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal
);

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [63:0] time_rd;

`ifdef CSR_TIME_EN
  logic [31:0] presc_q, presc_d;
  logic [63:0] tmr_q, tmr_d;

  always_comb begin
    presc_d = presc_q + 32'd1;
    tmr_d   = tmr_q;
    if (presc_q == 32'(TIME_DIV - 1)) begin
      presc_d = 32'd0;
      tmr_d   = tmr_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= 32'd0;
      tmr_q   <= 64'd0;
    end else begin
      presc_q <= presc_d;
      tmr_q   <= tmr_d;
    end
  end

  assign time_rd = tmr_q;
`else
  assign time_rd = mcycle_q;
`endif

  logic [31:0] rdata_raw;
  logic        mapped;
  logic        op_valid, op_rw, wants_write, read_only;
  logic        illegal_raw, we;
  logic [31:0] src, wdata;

  always_comb begin
    rdata_raw = 32'd0;
    mapped    = 1'b1;
    case (csr_addr)
      12'hC00, 12'hB00: rdata_raw = mcycle_q[31:0];
      12'hC80, 12'hB80: rdata_raw = mcycle_q[63:32];
      12'hC02, 12'hB02: rdata_raw = minstret_q[31:0];
      12'hC82, 12'hB82: rdata_raw = minstret_q[63:32];
      12'hC01:          rdata_raw = time_rd[31:0];
      12'hC81:          rdata_raw = time_rd[63:32];
      default:          mapped    = 1'b0;
    endcase
  end

  // Set/clear forms with rs1_idx == 0 are pure reads, so they may target read-only CSRs.
  assign op_valid    = (funct3[1:0] != 2'b00);
  assign op_rw       = (funct3[1:0] == 2'b01);
  assign wants_write = op_rw | (rs1_idx != 5'd0);
  assign read_only   = (csr_addr[11:10] == 2'b11);
  assign illegal_raw = csr_en & (~mapped | ~op_valid | (wants_write & read_only));
  assign we          = csr_en & ~illegal_raw & wants_write;

  assign src = funct3[2] ? {27'd0, rs1_idx} : rs1_data;

  always_comb begin
    case (funct3[1:0])
      2'b10:   wdata = rdata_raw | src;
      2'b11:   wdata = rdata_raw & ~src;
      default: wdata = src;
    endcase
  end

  assign csr_rdata   = reset ? 32'd0 : rdata_raw;
  assign csr_illegal = ~reset & illegal_raw;

  // A write to either half suppresses that counter's increment for the edge.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, icycle_inc};
    if (we) begin
      case (csr_addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], wdata};
        12'hB80: mcycle_d   = {wdata, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wdata};
        12'hB82: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule
